// File: rtl/uart_pkg.sv
// uart_pkg: shared defaults and state encodings for the UART echo block.
//   CLK_FREQ_DEF / BAUD_DEF : default clock frequency (Hz) and bit rate
//   rx_state_t / tx_state_t : receiver / transmitter FSM states
package uart_pkg;

  localparam int CLK_FREQ_DEF = 50_000_000;
  localparam int BAUD_DEF     = 115_200;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with input synchronizer and mid-bit sampling.
//   clk      in   system clock
//   rst_n    in   synchronous reset, active-high
//   rxd      in   serial input, idle high, asynchronous to clk
//   rx_done  out  one-cycle pulse when a byte with a valid stop bit arrives
//   rx_data  out  received byte, valid while rx_done is high
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronized input
// RX_START | timing to mid start bit; high there means a glitch
// RX_DATA  | sampling 8 data bits LSB first, one per bit period
// RX_STOP  | sampling the stop bit; low means framing error, byte dropped
module uart_rx
  import uart_pkg::*;
#(
  parameter int BIT_CYC  = 434,
  parameter int HALF_CYC = 217
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       rx_done,
  output logic [7:0] rx_data
);

  localparam int CNT_W = $clog2(BIT_CYC);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             rxd_meta;
  logic             rxd_sync;
  logic             rxd_prev;
  logic             rxd_fall;
  rx_state_t        state;
  rx_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       idx;
  logic [2:0]       idx_nxt;
  logic [7:0]       data_nxt;
  logic             done_nxt;

  assign rxd_fall = rxd_prev & ~rxd_sync;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
      state    <= RX_IDLE;
      cnt      <= '0;
      idx      <= '0;
      rx_data  <= '0;
      rx_done  <= 1'b0;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      rx_data  <= data_nxt;
      rx_done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    data_nxt  = rx_data;
    done_nxt  = 1'b0;
    unique case (state)
      RX_IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (rxd_fall) state_nxt = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          state_nxt = rxd_sync ? RX_IDLE : RX_DATA;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt       = '0;
          data_nxt[idx] = rxd_sync;
          if (idx == 3'd7) state_nxt = RX_STOP;
          else             idx_nxt   = idx + 3'd1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = RX_IDLE;
          done_nxt  = rxd_sync;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 transmitter with a registered, glitch-free serial output.
//   clk       in   system clock
//   rst_n     in   synchronous reset, active-high
//   tx_start  in   load tx_data and begin a frame (honoured only when idle)
//   tx_data   in   byte to send
//   tx_busy   out  high while a frame is in progress
//   txd       out  serial output, idle high
//
// state    | meaning
// TX_IDLE  | line high, waiting for tx_start
// TX_START | driving the start bit (0) for one bit period
// TX_DATA  | driving 8 data bits LSB first
// TX_STOP  | driving the stop bit (1) for one bit period
module uart_tx
  import uart_pkg::*;
#(
  parameter int BIT_CYC = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       txd
);

  localparam int CNT_W = $clog2(BIT_CYC);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  tx_state_t        state;
  tx_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       idx;
  logic [2:0]       idx_nxt;
  logic [7:0]       data_r;
  logic [7:0]       data_nxt;
  logic             txd_nxt;

  assign tx_busy = (state != TX_IDLE);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state  <= TX_IDLE;
      cnt    <= '0;
      idx    <= '0;
      data_r <= '0;
      txd    <= 1'b1;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      data_r <= data_nxt;
      txd    <= txd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    data_nxt  = data_r;
    unique case (state)
      TX_IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (tx_start) begin
          data_nxt  = tx_data;
          state_nxt = TX_START;
        end
      end
      TX_START: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = TX_DATA;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (idx == 3'd7) state_nxt = TX_STOP;
          else             idx_nxt   = idx + 3'd1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      TX_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = TX_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: state_nxt = TX_IDLE;
    endcase

    // Output is decoded from the next state so the line changes on the same
    // edge as the state register, straight out of a flop.
    unique case (state_nxt)
      TX_START: txd_nxt = 1'b0;
      TX_DATA:  txd_nxt = data_nxt[idx_nxt];
      default:  txd_nxt = 1'b1;
    endcase
  end

endmodule

// File: rtl/uart_echo.sv
// uart_echo: 8N1 serial loopback; each received byte is retransmitted as-is.
//   clk       in   system clock
//   rst_n     in   synchronous reset, active-high (1 = reset)
//   uart_rxd  in   serial input, idle high, asynchronous to clk
//   uart_txd  out  serial output, idle high
module uart_echo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int BAUD     = BAUD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic uart_rxd,
  output logic uart_txd
);

  localparam int BIT_CYC  = CLK_FREQ / BAUD;
  localparam int HALF_CYC = BIT_CYC / 2;

  logic       rx_done;
  logic [7:0] rx_data;
  logic [7:0] hold_data;
  logic       pending;
  logic       tx_busy;
  logic       tx_take;

  uart_rx #(
    .BIT_CYC  (BIT_CYC),
    .HALF_CYC (HALF_CYC)
  ) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .rxd     (uart_rxd),
    .rx_done (rx_done),
    .rx_data (rx_data)
  );

  assign tx_take = pending & ~tx_busy;

  // One-byte hold: a new byte always wins the register. If it lands in the
  // same cycle the transmitter takes the previous one, the old byte goes out
  // and the new one stays pending.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      hold_data <= '0;
      pending   <= 1'b0;
    end else if (rx_done) begin
      hold_data <= rx_data;
      pending   <= 1'b1;
    end else if (tx_take) begin
      pending   <= 1'b0;
    end
  end

  uart_tx #(
    .BIT_CYC (BIT_CYC)
  ) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_start (tx_take),
    .tx_data  (hold_data),
    .tx_busy  (tx_busy),
    .txd      (uart_txd)
  );

endmodule

// File: tb/tb_uart_echo.sv
// tb_uart_echo: directed bench for uart_echo at 50 MHz / 115200 baud.
module tb_uart_echo;

  localparam int BIT_CYC  = 434;
  localparam int HALF_CYC = 217;

  logic clk      = 1'b0;
  logic rst_n    = 1'b1;
  logic uart_rxd = 1'b1;
  logic uart_txd;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rx_done_cnt = 0;
  int rx_done_cyc = 0;
  int txd_lows = 0;
  int echo_starts = 0;
  int echo_start_cyc = 0;

  logic [7:0] echo_q[$];
  int         bad_q[$];
  logic       stop_q[$];

  uart_echo #(
    .CLK_FREQ (50_000_000),
    .BAUD     (115_200)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_rxd (uart_rxd),
    .uart_txd (uart_txd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (dut.rx_done === 1'b1) begin
      rx_done_cnt++;
      rx_done_cyc = cyc;
    end
    if (uart_txd === 1'b0) txd_lows++;
  end

  // Echo decoder: on a txd falling edge, sample each bit at mid-bit and flag
  // any transition that is not on a bit boundary of the frame.
  logic       mon_last = 1'b1;
  logic [7:0] mon_byte;
  logic       mon_stop;
  int         mon_bad;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_last === 1'b1 && uart_txd === 1'b0) begin
        echo_starts++;
        echo_start_cyc = cyc;
        mon_byte = '0;
        mon_stop = 1'b0;
        mon_bad  = 0;
        mon_last = 1'b0;
        for (int j = 1; j < 10 * BIT_CYC; j++) begin
          @(negedge clk);
          if (uart_txd !== mon_last && (j % BIT_CYC) != 0) mon_bad++;
          mon_last = uart_txd;
          if ((j % BIT_CYC) == HALF_CYC) begin
            if (j / BIT_CYC == 0) begin
              if (uart_txd !== 1'b0) mon_bad++;
            end else if (j / BIT_CYC == 9) begin
              mon_stop = uart_txd;
            end else begin
              mon_byte[j / BIT_CYC - 1] = uart_txd;
            end
          end
        end
        echo_q.push_back(mon_byte);
        bad_q.push_back(mon_bad);
        stop_q.push_back(mon_stop);
      end else begin
        mon_last = uart_txd;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    wait_cyc(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      wait_cyc(BIT_CYC);
    end
    uart_rxd = stop_bit;
    wait_cyc(BIT_CYC);
    uart_rxd = 1'b1;
  endtask

  task automatic wait_echo(input string tag, input int n);
    for (int i = 0; i < 12 * BIT_CYC && echo_q.size() < n; i++)
      @(posedge clk);
    #1;
    check_val(tag, echo_q.size(), n);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    logic [7:0] b;
    int         bad;
    logic       st;
    if (echo_q.size() == 0) begin
      check_val({tag, "_present"}, 0, 1);
    end else begin
      b   = echo_q.pop_front();
      bad = bad_q.pop_front();
      st  = stop_q.pop_front();
      check_val({tag, "_byte"}, b, exp);
      check_val({tag, "_bit_timing"}, bad, 0);
      check_val({tag, "_stop"}, st, 1);
    end
  endtask

  initial begin
    int base_done;
    int base_lows;
    int base_starts;
    int target;

    // Reset and idle line.
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_val("rst_txd", uart_txd, 1);
    check_val("rst_pending", dut.pending, 0);
    base_lows = txd_lows;
    wait_cyc(20 * BIT_CYC);
    check_val("rst_idle_lows", txd_lows - base_lows, 0);
    check_val("rst_rx_done", rx_done_cnt, 0);

    // Single byte 0x41.
    send_byte(8'h41, 1'b1);
    wait_echo("t1_echo_count", 1);
    check_val("t1_rx_done", rx_done_cnt, 1);
    check_val("t1_rx_data", dut.rx_data, 8'h41);
    check_val("t1_latency", echo_start_cyc - rx_done_cyc, 2);
    pop_check("t1", 8'h41);

    // Two bytes with 6 idle bit times between.
    base_done = rx_done_cnt;
    send_byte(8'h41, 1'b1);
    wait_cyc(6 * BIT_CYC);
    send_byte(8'h0F, 1'b1);
    wait_echo("t2_echo_count", 2);
    check_val("t2_rx_done", rx_done_cnt - base_done, 2);
    pop_check("t2_first", 8'h41);
    pop_check("t2_second", 8'h0F);

    // Short low glitch is rejected.
    base_done = rx_done_cnt;
    base_lows = txd_lows;
    uart_rxd = 1'b0;
    wait_cyc(100);
    uart_rxd = 1'b1;
    wait_cyc(12 * BIT_CYC);
    check_val("t3_rx_done", rx_done_cnt - base_done, 0);
    check_val("t3_txd_lows", txd_lows - base_lows, 0);
    check_val("t3_echo_count", echo_q.size(), 0);

    // Framing error dropped, following good byte echoed.
    base_done = rx_done_cnt;
    send_byte(8'h55, 1'b0);
    wait_cyc(2 * BIT_CYC);
    send_byte(8'hA3, 1'b1);
    wait_echo("t4_echo_count", 1);
    check_val("t4_rx_done", rx_done_cnt - base_done, 1);
    pop_check("t4", 8'hA3);

    // Reset in the middle of data bit 3 of an echo (0x35 has bit 3 = 0).
    base_starts = echo_starts;
    base_done   = rx_done_cnt;
    send_byte(8'h35, 1'b1);
    check_val("t5_echo_started", echo_starts - base_starts, 1);
    target = echo_start_cyc + 4 * BIT_CYC + 200;
    for (int i = 0; i < 4 * BIT_CYC && cyc < target; i++) @(negedge clk);
    @(negedge clk);
    check_val("t5_pre_txd", uart_txd, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_val("t5_post_txd", uart_txd, 1);
    check_val("t5_hold", dut.hold_data, 8'h00);
    check_val("t5_pending", dut.pending, 0);
    base_lows = txd_lows;
    wait_cyc(12 * BIT_CYC);
    check_val("t5_txd_lows", txd_lows - base_lows, 0);
    check_val("t5_rx_done", rx_done_cnt - base_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
